// File: rtl/ysyx_22051013_mem_arbiter.sv
// ysyx_22051013_mem_arbiter: round-robin share of one AXI bridge port between IC, DC and MMIO requesters
// Ports: clk/rst; ic_* read-only requester; dc_* and mm_* read/write requesters;
// err flags a watchdog-terminated completion; axi_* registered bridge request, axi_valid/axi_rdata bridge answer.
module ysyx_22051013_mem_arbiter #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64,
  parameter int TO_CYC = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ic_re,
  input  logic [ADDR_W-1:0] ic_addr,
  input  logic [2:0]        ic_size,
  output logic [DATA_W-1:0] ic_rdata,
  output logic              ic_done,
  input  logic              dc_re,
  input  logic              dc_we,
  input  logic [ADDR_W-1:0] dc_addr,
  input  logic [DATA_W-1:0] dc_wdata,
  input  logic [7:0]        dc_mask,
  input  logic [2:0]        dc_size,
  output logic [DATA_W-1:0] dc_rdata,
  output logic              dc_done,
  input  logic              mm_re,
  input  logic              mm_we,
  input  logic [ADDR_W-1:0] mm_addr,
  input  logic [DATA_W-1:0] mm_wdata,
  input  logic [7:0]        mm_mask,
  input  logic [2:0]        mm_size,
  output logic [DATA_W-1:0] mm_rdata,
  output logic              mm_done,
  output logic              err,
  output logic              axi_re,
  output logic              axi_we,
  output logic [ADDR_W-1:0] axi_addr,
  output logic [DATA_W-1:0] axi_wdata,
  output logic [7:0]        axi_mask,
  output logic [2:0]        axi_size,
  input  logic              axi_valid,
  input  logic [DATA_W-1:0] axi_rdata
);
  localparam int CW = TO_CYC > 0 ? $clog2(TO_CYC + 1) : 1;
  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_e;
  state_e            state_q;
  logic [1:0]        id_q, rr_q, n1, n2, gnt;
  logic [2:0]        pend, done_q;
  logic [CW-1:0]     cnt_q;
  logic              err_q, re_q, we_q, tmo, sel_we;
  logic [ADDR_W-1:0] addr_q, sel_addr;
  logic [DATA_W-1:0] wdata_q, sel_wdata;
  logic [7:0]        mask_q, sel_mask;
  logic [2:0]        size_q, sel_size;
  logic [DATA_W-1:0] rdata_q [3];
  assign pend = {mm_re | mm_we, dc_re | dc_we, ic_re};
  // ring IC(0) -> DC(1) -> MM(2); the last granted id has lowest priority
  assign n1 = rr_q == 2'd2 ? 2'd0 : rr_q + 2'd1;
  assign n2 = n1 == 2'd2 ? 2'd0 : n1 + 2'd1;
  assign gnt = pend[n1] ? n1 : pend[n2] ? n2 : rr_q;
  assign sel_we    = gnt == 2'd1 ? dc_we    : gnt == 2'd2 ? mm_we    : 1'b0;
  assign sel_addr  = gnt == 2'd1 ? dc_addr  : gnt == 2'd2 ? mm_addr  : ic_addr;
  assign sel_wdata = gnt == 2'd1 ? dc_wdata : gnt == 2'd2 ? mm_wdata : '0;
  assign sel_mask  = gnt == 2'd1 ? dc_mask  : gnt == 2'd2 ? mm_mask  : 8'hff;
  assign sel_size  = gnt == 2'd1 ? dc_size  : gnt == 2'd2 ? mm_size  : ic_size;
  // cnt_q counts completed BUSY cycles, so the last allowed cycle sees TO_CYC-1
  assign tmo = (TO_CYC != 0) && (cnt_q == CW'(TO_CYC - 1));
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      id_q    <= 2'd0;
      rr_q    <= 2'd0;
      cnt_q   <= '0;
      done_q  <= '0;
      err_q   <= 1'b0;
      re_q    <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      mask_q  <= '0;
      size_q  <= '0;
      rdata_q <= '{default: '0};
    end else begin
      done_q <= '0;
      err_q  <= 1'b0;
      case (state_q)
        IDLE: if (|pend) begin
          re_q    <= ~sel_we;
          we_q    <= sel_we;
          addr_q  <= sel_addr;
          wdata_q <= sel_wdata;
          mask_q  <= sel_mask;
          size_q  <= sel_size;
          id_q    <= gnt;
          rr_q    <= gnt;
          cnt_q   <= '0;
          state_q <= BUSY;
        end
        BUSY: if (axi_valid || tmo) begin
          re_q            <= 1'b0;
          we_q            <= 1'b0;
          done_q[id_q]    <= 1'b1;
          err_q           <= ~axi_valid;
          rdata_q[id_q]   <= axi_valid ? axi_rdata : '0;
          state_q         <= RESP;
        end else begin
          cnt_q <= cnt_q + 1'b1;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign {mm_done, dc_done, ic_done} = done_q;
  assign ic_rdata  = rdata_q[0];
  assign dc_rdata  = rdata_q[1];
  assign mm_rdata  = rdata_q[2];
  assign err       = err_q;
  assign axi_re    = re_q;
  assign axi_we    = we_q;
  assign axi_addr  = addr_q;
  assign axi_wdata = wdata_q;
  assign axi_mask  = mask_q;
  assign axi_size  = size_q;
endmodule

// File: tb/tb_ysyx_22051013_mem_arbiter.sv
// tb_ysyx_22051013_mem_arbiter: transaction-level model plus directed scenarios for the memory arbiter
module tb_ysyx_22051013_mem_arbiter;
  localparam int TO = 8;
  logic clk = 0, rst = 1;
  always #5 clk = ~clk;
  logic        ic_re = 0, dc_re = 0, dc_we = 0, mm_re = 0, mm_we = 0;
  logic [63:0] ic_addr = 0, dc_addr = 0, mm_addr = 0, dc_wdata = 0, mm_wdata = 0;
  logic [7:0]  dc_mask = 0, mm_mask = 0;
  logic [2:0]  ic_size = 0, dc_size = 0, mm_size = 0;
  logic [63:0] ic_rdata, dc_rdata, mm_rdata, axi_addr, axi_wdata, axi_rdata;
  logic        ic_done, dc_done, mm_done, err, axi_re, axi_we;
  logic [7:0]  axi_mask;
  logic [2:0]  axi_size;
  logic        axi_valid = 0;
  int          lat = 1, bcnt = 0;
  logic [63:0] bdata = 0;
  int          npass = 0, ntot = 0;
  logic        chk_en = 0, ic_hold = 0;
  assign axi_rdata = bdata;

  ysyx_22051013_mem_arbiter #(.ADDR_W(64), .DATA_W(64), .TO_CYC(TO)) dut (
    .clk(clk), .rst(rst),
    .ic_re(ic_re), .ic_addr(ic_addr), .ic_size(ic_size), .ic_rdata(ic_rdata), .ic_done(ic_done),
    .dc_re(dc_re), .dc_we(dc_we), .dc_addr(dc_addr), .dc_wdata(dc_wdata), .dc_mask(dc_mask),
    .dc_size(dc_size), .dc_rdata(dc_rdata), .dc_done(dc_done),
    .mm_re(mm_re), .mm_we(mm_we), .mm_addr(mm_addr), .mm_wdata(mm_wdata), .mm_mask(mm_mask),
    .mm_size(mm_size), .mm_rdata(mm_rdata), .mm_done(mm_done),
    .err(err), .axi_re(axi_re), .axi_we(axi_we), .axi_addr(axi_addr), .axi_wdata(axi_wdata),
    .axi_mask(axi_mask), .axi_size(axi_size), .axi_valid(axi_valid), .axi_rdata(axi_rdata)
  );

  // bridge: answers in the lat-th cycle of a request; lat == 0 never answers
  always @(negedge clk) begin
    if (axi_re || axi_we) begin
      bcnt = bcnt + 1;
      axi_valid = (lat != 0) && (bcnt == lat);
    end else begin
      bcnt = 0;
      axi_valid = 0;
    end
  end

  task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
    ntot++;
    if (a === e) npass++;
    else $display("FAIL %s got %h expected %h", n, a, e);
  endtask

  // transaction model: a grant lasts dur edges (bridge latency or watchdog), then one response cycle
  logic        m_act = 0, m_tmo = 0;
  int          m_k = 0, m_dur = 0, m_last = 0;
  logic [1:0]  m_id = 0;
  logic        e_re = 0, e_we = 0, e_err = 0;
  logic [2:0]  e_done = 0, e_size = 0;
  logic [7:0]  e_mask = 0;
  logic [63:0] e_addr = 0, e_wdata = 0;
  logic [63:0] e_rdata [3] = '{default: 0};
  always @(posedge clk) begin : model
    logic [2:0] p;
    int c;
    e_done = 0;
    e_err = 0;
    if (rst) begin
      m_act = 0; m_last = 0;
      e_re = 0; e_we = 0; e_addr = 0; e_wdata = 0; e_mask = 0; e_size = 0;
      e_rdata = '{default: 0};
    end else if (m_act) begin
      m_k++;
      if (m_k == m_dur) begin
        e_re = 0; e_we = 0;
        e_done[m_id] = 1;
        e_err = m_tmo;
        e_rdata[m_id] = m_tmo ? 64'h0 : bdata;
      end else if (m_k > m_dur) m_act = 0;
    end else begin
      p = {mm_re | mm_we, dc_re | dc_we, ic_re};
      for (int s = 1; s <= 3; s++) begin
        c = (m_last + s) % 3;
        if (!m_act && p[c]) begin
          m_act = 1; m_id = 2'(c); m_last = c; m_k = 0;
          m_tmo = !(lat != 0 && lat <= TO);
          m_dur = m_tmo ? TO : lat;
          case (c)
            0: begin e_re = 1; e_we = 0; e_addr = ic_addr; e_wdata = 0; e_mask = 8'hff; e_size = ic_size; end
            1: begin e_re = !dc_we; e_we = dc_we; e_addr = dc_addr; e_wdata = dc_wdata; e_mask = dc_mask; e_size = dc_size; end
            default: begin e_re = !mm_we; e_we = mm_we; e_addr = mm_addr; e_wdata = mm_wdata; e_mask = mm_mask; e_size = mm_size; end
          endcase
        end
      end
    end
  end

  always @(negedge clk) if (chk_en) begin
    chk("axi_re", axi_re, e_re);
    chk("axi_we", axi_we, e_we);
    chk("axi_addr", axi_addr, e_addr);
    chk("axi_wdata", axi_wdata, e_wdata);
    chk("axi_mask", axi_mask, e_mask);
    chk("axi_size", axi_size, e_size);
    chk("done", {mm_done, dc_done, ic_done}, e_done);
    chk("err", err, e_err);
    chk("ic_rdata", ic_rdata, e_rdata[0]);
    chk("dc_rdata", dc_rdata, e_rdata[1]);
    chk("mm_rdata", mm_rdata, e_rdata[2]);
  end

  // a requester drops its request in the cycle it sees its done
  task automatic cyc();
    @(negedge clk);
    #1;
    if (ic_done && !ic_hold) ic_re = 0;
    if (dc_done) begin dc_re = 0; dc_we = 0; end
    if (mm_done) begin mm_re = 0; mm_we = 0; end
  endtask

  task automatic drain();
    int i = 0;
    while ((ic_re || dc_re || dc_we || mm_re || mm_we) && i < 80) begin cyc(); i++; end
    chk("drain_left", {ic_re, dc_re | dc_we, mm_re | mm_we}, 0);
    repeat (3) cyc();
  endtask

  initial begin
    int n, got, cnt, run, maxrun, icn, first;
    int ord [3];
    logic seen;
    cyc(); cyc();
    chk_en = 1;
    chk("rst_axi_re", axi_re, 0);
    chk("rst_dc_rdata", dc_rdata, 0);
    rst = 0;
    // single DC read, 5-cycle bridge
    lat = 5; bdata = 64'h1122334455667788;
    dc_re = 1; dc_addr = 64'h8000_0000; dc_size = 3;
    n = 0; got = 0;
    for (int i = 0; i < 20; i++) begin
      cyc();
      n += int'(axi_re);
      if (dc_done) begin got++; chk("t1_rdata", dc_rdata, 64'h1122334455667788); end
    end
    chk("t1_re_cycles", n, 5);
    chk("t1_done_count", got, 1);
    // simultaneous requests after reset: DC, MM, IC
    rst = 1; cyc(); rst = 0;
    lat = 3; bdata = 64'h0bad_cafe_0000_0001;
    ic_re = 1; ic_addr = 64'h3000_0000; ic_size = 3;
    dc_re = 1; dc_addr = 64'h8000_0040; dc_size = 3;
    mm_re = 1; mm_addr = 64'h1000_0008; mm_size = 2; mm_mask = 8'h0f;
    ord = '{-1, -1, -1}; cnt = 0;
    for (int i = 0; i < 40; i++) begin
      cyc();
      if (dc_done) begin if (cnt < 3) ord[cnt] = 1; cnt++; end
      if (mm_done) begin if (cnt < 3) ord[cnt] = 2; cnt++; end
      if (ic_done) begin if (cnt < 3) ord[cnt] = 0; cnt++; end
    end
    chk("t2_count", cnt, 3);
    chk("t2_first", ord[0], 1);
    chk("t2_second", ord[1], 2);
    chk("t2_third", ord[2], 0);
    // re and we together: write wins
    lat = 2; bdata = 64'h5555_6666_7777_8888;
    dc_re = 1; dc_we = 1; dc_wdata = 64'hdead_beef; dc_mask = 8'h0f; dc_addr = 64'h8000_0100; dc_size = 2;
    seen = 0;
    for (int i = 0; i < 15; i++) begin
      cyc();
      if (axi_we && !seen) begin
        seen = 1;
        chk("t3_re", axi_re, 0);
        chk("t3_mask", axi_mask, 8'h0f);
        chk("t3_wdata", axi_wdata, 64'hdead_beef);
      end
    end
    chk("t3_we_seen", seen, 1);
    // IC held continuously against repeated DC requests
    dc_we = 0; dc_mask = 8'hff; bdata = 64'h0123_4567_89ab_cdef;
    ic_hold = 1; ic_re = 1; dc_re = 1;
    run = 0; maxrun = 0; icn = 0;
    for (int i = 0; i < 60; i++) begin
      cyc();
      if (!dc_re && !dc_done) dc_re = 1;
      if (dc_done) begin run++; if (run > maxrun) maxrun = run; end
      if (ic_done) begin run = 0; icn++; end
    end
    ic_hold = 0;
    drain();
    chk("t4_dc_run", maxrun, 1);
    chk("t4_ic_served", icn >= 5, 1);
    // watchdog timeout, then exact-boundary answer
    lat = 0; mm_re = 1;
    n = 0; got = 0;
    for (int i = 0; i < 20; i++) begin
      cyc();
      n += int'(axi_re);
      if (mm_done) begin got++; chk("t5_err", err, 1); chk("t5_rdata", mm_rdata, 0); end
    end
    chk("t5_re_cycles", n, 8);
    chk("t5_done_count", got, 1);
    lat = 8; bdata = 64'ha5a5_a5a5_5a5a_5a5a; mm_re = 1;
    got = 0;
    for (int i = 0; i < 20; i++) begin
      cyc();
      if (mm_done) begin got++; chk("t5b_err", err, 0); chk("t5b_rdata", mm_rdata, 64'ha5a5_a5a5_5a5a_5a5a); end
    end
    chk("t5b_done_count", got, 1);
    // reset in the middle of BUSY
    lat = 0; dc_re = 1;
    repeat (3) cyc();
    chk("t6_busy", axi_re, 1);
    rst = 1; cyc();
    chk("t6_axi_re", axi_re, 0);
    chk("t6_done", {mm_done, dc_done, ic_done}, 0);
    chk("t6_dc_rdata", dc_rdata, 0);
    chk("t6_mm_rdata", mm_rdata, 0);
    dc_re = 0; rst = 0;
    lat = 2; ic_re = 1; first = -1;
    for (int i = 0; i < 12; i++) begin
      cyc();
      if (first < 0 && (ic_done || dc_done || mm_done)) first = ic_done ? 0 : dc_done ? 1 : 2;
    end
    chk("t6_first", first, 0);
    drain();
    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end
endmodule
